alu: RTL and testbench



---
 rtl/alu.sv | 167 ++++++++++++++++
 tb/tb_alu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 4-bit registered arithmetic logic unit
//
// Single compute stage of the datapath. Operands, opcode and carry-in are
// sampled on the rising clock edge when en is high; the result and status
// flags appear on registered outputs one cycle later. No combinational path
// exists from any input to any output.
//
// Configuration macro: ALU_FLAGS_EN
//   defined   : cout/zero/neg/ovf are computed and registered.
//   undefined : the four flag outputs are constant 0 (zero included, even
//               during reset) and no flag logic is built. y is unaffected.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous, active-high reset
//   en    in   1  capture enable; low holds every output
//   s     in   3  operation select
//   a     in   4  operand A
//   b     in   4  operand B
//   cin   in   1  carry-in (used by s=001 and s=011)
//   y     out  4  registered result
//   cout  out  1  registered carry out of bit 3 (0 for logic ops)
//   zero  out  1  registered y == 0
//   neg   out  1  registered y[3]
//   ovf   out  1  registered signed overflow (0 for logic ops)
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] s,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout,
  output logic       zero,
  output logic       neg,
  output logic       ovf
);

  // Opcode encodings
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  logic [3:0] opnd_b_s;    // second adder operand: b, or ~b for subtracts
  logic       carry_in_s;  // adder carry-in for the selected opcode
`ifdef ALU_FLAGS_EN
  logic [4:0] sum_s;       // bit 4 is the carry out of bit 3
`else
  logic [3:0] sum_s;       // carry out is not needed without flags
`endif
  logic [3:0] y_d;
  logic [3:0] y_q;

  // Adder operand and carry selection; s[1] marks the subtracting opcodes
  always_comb begin
    opnd_b_s   = 4'h0;
    carry_in_s = 1'b0;
    if (s[1]) begin
      opnd_b_s = ~b;
    end else begin
      opnd_b_s = b;
    end
    case (s)
      OP_ADD:  carry_in_s = 1'b0;
      OP_ADC:  carry_in_s = cin;
      OP_SUB:  carry_in_s = 1'b1;
      OP_SBC:  carry_in_s = cin;
      default: carry_in_s = 1'b0;
    endcase
  end

  // Shared adder, widened by one bit when the carry is needed
  always_comb begin
`ifdef ALU_FLAGS_EN
    sum_s = {1'b0, a} + {1'b0, opnd_b_s} + {4'b0000, carry_in_s};
`else
    sum_s = a + opnd_b_s + {3'b000, carry_in_s};
`endif
  end

  // Result multiplexer
  always_comb begin
    y_d = 4'h0;
    case (s)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: y_d = sum_s[3:0];
      OP_AND:  y_d = a & b;
      OP_OR:   y_d = a | b;
      OP_XOR:  y_d = a ^ b;
      OP_NOTA: y_d = ~a;
      default: y_d = 4'h0;
    endcase
  end

  // Result register; rst wins over en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 4'h0;
    end else if (en) begin
      y_q <= y_d;
    end else begin
      y_q <= y_q;
    end
  end

  assign y = y_q;

`ifdef ALU_FLAGS_EN
  logic cout_d, zero_d, neg_d, ovf_d;
  logic cout_q, zero_q, neg_q, ovf_q;

  // Flag next-state; logic ops (s[2]=1) force cout and ovf low
  always_comb begin
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    zero_d = (y_d == 4'h0);
    neg_d  = y_d[3];
    if (s[2]) begin
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      cout_d = sum_s[4];
      // Same-sign adder operands producing a result of the other sign
      ovf_d  = (a[3] == opnd_b_s[3]) && (sum_s[3] != a[3]);
    end
  end

  // Flag registers; zero reflects the reset value y=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      cout_q <= cout_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end else begin
      cout_q <= cout_q;
      zero_q <= zero_q;
      neg_q  <= neg_q;
      ovf_q  <= ovf_q;
    end
  end

  assign cout = cout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  assign cout = 1'b0;
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu
//
// Directed steps from the test plan followed by a randomized run, all
// compared against a reference model that evaluates each opcode with plain
// integer arithmetic. Flag expectations follow ALU_FLAGS_EN the same way the
// design does.
// ---------------------------------------------------------------------------
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] s;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] y;
  logic       cout;
  logic       zero;
  logic       neg;
  logic       ovf;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: what the outputs must currently show
  logic [3:0] m_y;
  logic       m_cout, m_zero, m_neg, m_ovf;

  logic [3:0] sweep_y [8];

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .s    (s),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .y    (y),
    .cout (cout),
    .zero (zero),
    .neg  (neg),
    .ovf  (ovf)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_y"},    y,               m_y);
    chk({tag, "_cout"}, {3'b000, cout},  {3'b000, m_cout});
    chk({tag, "_zero"}, {3'b000, zero},  {3'b000, m_zero});
    chk({tag, "_neg"},  {3'b000, neg},   {3'b000, m_neg});
    chk({tag, "_ovf"},  {3'b000, ovf},   {3'b000, m_ovf});
  endtask

  task automatic model_reset();
    m_y    = 4'h0;
    m_cout = 1'b0;
    m_neg  = 1'b0;
    m_ovf  = 1'b0;
`ifdef ALU_FLAGS_EN
    m_zero = 1'b1;
`else
    m_zero = 1'b0;
`endif
  endtask

  // Evaluate one operation from its arithmetic definition
  task automatic model_step(input logic [2:0] op, input logic [3:0] av,
                            input logic [3:0] bv, input logic cv);
    int ia, ib, opb, c, sum, r, sa, so, sr;
    logic co, ov;
    ia = int'(av);
    ib = int'(bv);
    opb = 0; c = 0; r = 0; co = 1'b0; ov = 1'b0;
    if (op < 3'd4) begin
      case (op)
        3'd0:    begin opb = ib;      c = 0;       end
        3'd1:    begin opb = ib;      c = int'(cv); end
        3'd2:    begin opb = 15 - ib; c = 1;       end
        default: begin opb = 15 - ib; c = int'(cv); end
      endcase
      sum = ia + opb + c;
      r   = sum % 16;
      co  = (sum >= 16);
      sa  = (ia >= 8) ? ia - 16 : ia;
      so  = (opb >= 8) ? opb - 16 : opb;
      sr  = sa + so + c;
      ov  = (sr > 7) || (sr < -8);
    end else begin
      case (op)
        3'd4:    r = ia & ib;
        3'd5:    r = ia | ib;
        3'd6:    r = ia ^ ib;
        default: r = 15 - ia;
      endcase
    end
    m_y = 4'(r);
`ifdef ALU_FLAGS_EN
    m_cout = co;
    m_zero = (r == 0);
    m_neg  = (r >= 8);
    m_ovf  = ov;
`else
    m_cout = 1'b0;
    m_zero = 1'b0;
    m_neg  = 1'b0;
    m_ovf  = 1'b0;
`endif
  endtask

  // Drive one operation, let one edge pass, check on the falling edge
  task automatic do_op(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv,
                       input logic cv, input logic env, input string tag);
    s = op; a = av; b = bv; cin = cv; en = env;
    @(posedge clk);
    if (env) model_step(op, av, bv, cv);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    sweep_y = '{4'hD, 4'hE, 4'h9, 4'h9, 4'h2, 4'hB, 4'h9, 4'hC};

    // Reset with arbitrary inputs, before any clock edge
    rst = 1'b1;
    en  = 1'b1;
    s   = 3'($urandom_range(0, 7));
    a   = 4'($urandom_range(0, 15));
    b   = 4'($urandom_range(0, 15));
    cin = 1'($urandom_range(0, 1));
    #3;
    model_reset();
    check_outputs("reset_async");
    chk("reset_y_const", y, 4'h0);
    #4;
    rst = 1'b0;

    do_op(3'd0, 4'h3, 4'hA, 1'b0, 1'b1, "first_capture");
    chk("first_capture_const", y, 4'hD);

    // Opcode sweep with an asynchronous reset pulse between edges
    for (int i = 0; i < 8; i++) begin
      do_op(3'(i), 4'h3, 4'hA, 1'b1, 1'b1, $sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d_const", i), y, sweep_y[i]);
      chk($sformatf("sweep%0d_cout0", i), {3'b000, cout}, 4'h0);
      if (i == 3) begin
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_outputs("mid_reset");
        #2 rst = 1'b0;
      end
    end

    // Carry, zero and signed overflow corners
    do_op(3'd0, 4'hF, 4'h1, 1'b0, 1'b1, "add_carry");
    chk("add_carry_const", y, 4'h0);
    do_op(3'd2, 4'h5, 4'h5, 1'b0, 1'b1, "sub_equal");
    chk("sub_equal_const", y, 4'h0);
    do_op(3'd0, 4'h7, 4'h1, 1'b0, 1'b1, "add_ovf");
    chk("add_ovf_const", y, 4'h8);
    do_op(3'd2, 4'h8, 4'h1, 1'b0, 1'b1, "sub_ovf");
    chk("sub_ovf_const", y, 4'h7);
    do_op(3'd3, 4'h0, 4'h0, 1'b0, 1'b1, "sbc_borrow");
    do_op(3'd1, 4'hF, 4'hF, 1'b1, 1'b1, "adc_full");

    // Enable hold: capture OR, then three cycles of en low with new inputs
    do_op(3'd5, 4'h3, 4'hA, 1'b0, 1'b1, "hold_capture");
    for (int i = 0; i < 3; i++) begin
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0,
            $sformatf("hold%0d", i));
      chk($sformatf("hold%0d_const", i), y, 4'hB);
    end

    // Randomized run
    for (int i = 0; i < 300; i++) begin
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
